// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding memory request, a single-entry
// instruction holding register, redirect/squash handling and a sticky misalignment fault.
module fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   output logic        o_MemReq,
   output logic [31:0] o_MemAddr,
   input  logic        i_MemGrant,
   input  logic        i_MemRespValid,
   input  logic [31:0] i_MemRespData,
   output logic        o_InstrValid,
   output logic [31:0] o_InstrData,
   output logic [31:0] o_InstrAddress,
   input  logic        i_InstrReady,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectAddress,
   output logic        o_Fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_SQUASH,
      S_FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_data_q, instr_data_d;
   logic [31:0] instr_addr_q, instr_addr_d;
   logic        redirect_misaligned;

   assign redirect_misaligned = (i_RedirectAddress[1:0] != 2'b00);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_VECTOR;
         instr_data_q <= '0;
         instr_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_data_q <= instr_data_d;
         instr_addr_q <= instr_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_data_d = instr_data_q;
      instr_addr_d = instr_addr_q;

      if (i_Redirect && (state_q != S_FAULT)) begin
         pc_d = i_RedirectAddress;
         if (redirect_misaligned) begin
            state_d = S_FAULT;
         end else begin
            case (state_q)
               S_IDLE:   state_d = S_REQ;
               S_REQ:    state_d = i_MemGrant ? S_SQUASH : S_REQ;
               S_WAIT:   state_d = i_MemRespValid ? S_REQ : S_SQUASH;
               S_HOLD:   state_d = S_REQ;
               // A response landing with the redirect retires the squashed fetch;
               // waiting for another would never end.
               S_SQUASH: state_d = i_MemRespValid ? S_REQ : S_SQUASH;
               default:  state_d = S_IDLE;
            endcase
         end
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (i_MemGrant) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (i_MemRespValid) begin
                  instr_data_d = i_MemRespData;
                  instr_addr_d = pc_q;
                  state_d      = S_HOLD;
               end
            end
            S_HOLD: begin
               if (i_InstrReady) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_REQ;
               end
            end
            S_SQUASH: begin
               if (i_MemRespValid) state_d = S_REQ;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign o_MemReq       = (state_q == S_REQ);
   assign o_MemAddr      = pc_q;
   assign o_InstrValid   = (state_q == S_HOLD);
   assign o_InstrData    = instr_data_q;
   assign o_InstrAddress = instr_addr_q;
   assign o_Fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: table of per-cycle inputs and expected
// registered outputs, plus hand sequences around asynchronous reset.
module tb_fetch_controller;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_grant;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_addr;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        fault;

   int unsigned n_vec;
   int unsigned n_bad;

   typedef struct {
      logic        redir;
      logic [31:0] raddr;
      logic        grant;
      logic        rv;
      logic [31:0] rdata;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_idata;
      logic [31:0] e_iaddr;
      logic        e_fault;
   } vec_t;

   vec_t tbl[$];

   fetch_controller #(.RESET_VECTOR(32'h0000_0000)) dut (
      .i_Clock          (clk),
      .i_Reset          (rst),
      .o_MemReq         (mem_req),
      .o_MemAddr        (mem_addr),
      .i_MemGrant       (mem_grant),
      .i_MemRespValid   (resp_valid),
      .i_MemRespData    (resp_data),
      .o_InstrValid     (instr_valid),
      .o_InstrData      (instr_data),
      .o_InstrAddress   (instr_addr),
      .i_InstrReady     (instr_ready),
      .i_Redirect       (redirect),
      .i_RedirectAddress(redirect_addr),
      .o_Fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic redir, input logic [31:0] raddr, input logic grant,
      input logic rv, input logic [31:0] rdata, input logic ready,
      input logic e_req, input logic [31:0] e_addr, input logic e_iv,
      input logic [31:0] e_idata, input logic [31:0] e_iaddr, input logic e_fault);
      vec_t v;
      v.redir = redir; v.raddr = raddr; v.grant = grant;
      v.rv = rv; v.rdata = rdata; v.ready = ready;
      v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
      v.e_idata = e_idata; v.e_iaddr = e_iaddr; v.e_fault = e_fault;
      return v;
   endfunction

   task automatic check(input string name, input vec_t v);
      n_vec++;
      if (mem_req !== v.e_req || mem_addr !== v.e_addr || instr_valid !== v.e_iv ||
          instr_data !== v.e_idata || instr_addr !== v.e_iaddr || fault !== v.e_fault) begin
         n_bad++;
         $display("FAIL %s: got req=%b addr=%h iv=%b idata=%h iaddr=%h fault=%b, want req=%b addr=%h iv=%b idata=%h iaddr=%h fault=%b",
                  name, mem_req, mem_addr, instr_valid, instr_data, instr_addr, fault,
                  v.e_req, v.e_addr, v.e_iv, v.e_idata, v.e_iaddr, v.e_fault);
      end
   endtask

   // Called at a negedge: drive, clock once, sample 1 time unit after the edge.
   task automatic step(input string name, input vec_t v);
      redirect      = v.redir;
      redirect_addr = v.raddr;
      mem_grant     = v.grant;
      resp_valid    = v.rv;
      resp_data     = v.rdata;
      instr_ready   = v.ready;
      @(posedge clk);
      #1;
      check(name, v);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      redirect = 1'b0; redirect_addr = '0; mem_grant = 1'b0;
      resp_valid = 1'b0; resp_data = '0; instr_ready = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      idle_inputs();
      rst = 1'b1;

      // redir raddr grant rv rdata ready | req addr iv idata iaddr fault
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     1, 32'h0, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'h0, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h0, 0, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0013, 0,         0, 32'h0, 1, 32'h13, 32'h0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,                     1, 32'h4, 0, 32'h13, 32'h0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'h4, 0, 32'h13, 32'h0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,         0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'h1111_1111, 0,         0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h4, 1, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,                     1, 32'h8, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(1, 32'h200, 0, 0, 0, 0,               1, 32'h200, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(1, 32'h300, 1, 0, 0, 0,               0, 32'h300, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'h2222_2222, 0,         1, 32'h300, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'h300, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0,               0, 32'h100, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,                     0, 32'h100, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0055, 0,         1, 32'h100, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'h100, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(1, 32'h180, 0, 1, 32'h0000_0066, 0,   1, 32'h180, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'h180, 0, 32'hDEAD_BEEF, 32'h4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0077, 0,         0, 32'h180, 1, 32'h77, 32'h180, 0));
      tbl.push_back(mk(1, 32'h40, 0, 0, 0, 1,                1, 32'h40, 0, 32'h77, 32'h180, 0));
      tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,         1, 32'hFFFF_FFFC, 0, 32'h77, 32'h180, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,                     0, 32'hFFFF_FFFC, 0, 32'h77, 32'h180, 0));
      tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0088, 0,         0, 32'hFFFF_FFFC, 1, 32'h88, 32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,                     1, 32'h0, 0, 32'h88, 32'hFFFF_FFFC, 0));
      tbl.push_back(mk(1, 32'h102, 0, 0, 0, 0,               0, 32'h102, 0, 32'h88, 32'hFFFF_FFFC, 1));
      tbl.push_back(mk(1, 32'h200, 1, 1, 32'h3333_3333, 1,   0, 32'h102, 0, 32'h88, 32'hFFFF_FFFC, 1));
      tbl.push_back(mk(1, 32'h201, 0, 0, 0, 0,               0, 32'h102, 0, 32'h88, 32'hFFFF_FFFC, 1));

      // Reset is asserted before the first edge: outputs must already be cleared.
      #1;
      check("reset_initial", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      // Asynchronous reset out of FAULT, between clock edges.
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      check("reset_async_from_fault", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      @(negedge clk);
      rst = 1'b0;

      // Reset abandons a fetch in WAIT; its late response must be ignored.
      step("r32_req",   mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0, 0));
      step("r32_grant", mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      #2 rst = 1'b1;
      #1;
      check("r32_reset_in_wait", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      @(negedge clk);
      rst = 1'b0;
      step("r32_late_resp_idle", mk(0, 0, 0, 1, 32'h9999_9999, 0, 1, 32'h0, 0, 32'h0, 32'h0, 0));
      step("r32_late_resp_req",  mk(0, 0, 0, 1, 32'h9999_9999, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0));
      step("r32_grant2",         mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      step("fault_from_wait",    mk(1, 32'h101, 0, 1, 32'hAAAA_AAAA, 0, 0, 32'h101, 0, 32'h0, 32'h0, 1));
      step("fault_sticky",       mk(0, 0, 1, 1, 32'hBBBB_BBBB, 1, 0, 32'h101, 0, 32'h0, 32'h0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, fetch address loaded on reset.
REQ-002 i_Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 o_MemReq  output  1  fetch request valid.
REQ-005 o_MemAddr  output  32  fetch address; equals PC register.
REQ-006 i_MemGrant  input  1  memory accepts request this cycle when o_MemReq=1.
REQ-007 i_MemRespValid  input  1  read data valid; arrives >=1 cycle after grant.
REQ-008 i_MemRespData  input  32  instruction word.
REQ-009 o_InstrValid  output  1  instruction available to decode.
REQ-010 o_InstrData  output  32  held instruction word.
REQ-011 o_InstrAddress  output  32  address of held instruction.
REQ-012 i_InstrReady  input  1  decode accepts instruction when o_InstrValid=1.
REQ-013 i_Redirect  input  1  taken jump/branch from execute.
REQ-014 i_RedirectAddress  input  32  redirect target.
REQ-015 o_Fault  output  1  misaligned redirect fault, sticky.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD, SQUASH, FAULT; at most one memory request outstanding.
REQ-017 Outputs: o_MemReq=1 only in REQ; o_InstrValid=1 only in HOLD; o_Fault=1 only in FAULT; all registered-state decodes, no combinational path from inputs.
REQ-018 IDLE -> REQ unconditionally on the first clock after reset release.
REQ-019 REQ: grant without redirect -> WAIT; no grant -> stay REQ.
REQ-020 WAIT: response without redirect -> capture i_MemRespData into o_InstrData, PC into o_InstrAddress, -> HOLD.
REQ-021 HOLD: o_InstrData/o_InstrAddress stable; i_InstrReady without redirect -> PC<=PC+4, -> REQ.
REQ-022 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect has priority over every other event in every state except FAULT; PC<=i_RedirectAddress.
REQ-024 Redirect in REQ: with same-cycle grant -> SQUASH; without grant -> stay REQ with new address (memory samples address only on grant).
REQ-025 Redirect in WAIT: with same-cycle response -> discard response, -> REQ; without response -> SQUASH.
REQ-026 SQUASH: o_MemReq=0, o_InstrValid=0; next response discarded, -> REQ; redirect in SQUASH updates PC, stays SQUASH.
REQ-027 Redirect in HOLD (with or without i_InstrReady) -> drop held instruction, no handshake completes, -> REQ.
REQ-028 Redirect with i_RedirectAddress[1:0]!=0 -> FAULT from any state; PC loads the target.
REQ-029 FAULT is terminal until reset; responses and redirects ignored.
REQ-030 Responses arriving in IDLE, REQ, HOLD or FAULT SHALL be ignored (protocol violation, no state change).

Reset
REQ-031 Asserting i_Reset SHALL immediately force state IDLE, PC=RESET_VECTOR, o_MemReq=0, o_InstrValid=0, o_Fault=0, o_InstrData=0, o_InstrAddress=0, regardless of clock.
REQ-032 Reset mid-request abandons the outstanding fetch; a late response after reset release (before next grant) SHALL be ignored.

Verification
REQ-033 Reset release, grant in first REQ cycle, response 2 cycles later with 32'h0000_0013, ready=1 -> o_InstrValid 1 cycle, o_InstrAddress=0, next o_MemAddr=4.
REQ-034 HOLD with i_InstrReady=0 for 5 cycles -> o_InstrValid, data, address stable all 5 cycles; no new o_MemReq.
REQ-035 Redirect to 32'h0000_0100 in WAIT without response -> SQUASH, next response discarded (o_InstrValid stays 0), then o_MemReq=1 with o_MemAddr=32'h0000_0100.
REQ-036 Redirect to 32'h0000_0040 same cycle as i_InstrReady in HOLD -> instruction dropped, next o_MemAddr=32'h0000_0040.
REQ-037 Redirect to 32'h0000_0102 -> o_Fault=1, o_MemReq=0 held until reset; subsequent redirects ignored.
REQ-038 Redirect to 32'hFFFF_FFFC, fetch completes, accepted -> next o_MemAddr=32'h0000_0000.
